// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: access-size encodings, responder FSM states and lane helpers
package riscv_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return size == SIZE_B ? 4'b0001 << off :
               size == SIZE_H ? 4'b0011 << {off[1], 1'b0} :
               size == SIZE_W ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
        return size == 2'b11 || (size == SIZE_H && off[0]) || (size == SIZE_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-wide storage with byte-enable synchronous write and combinational read
module dmem_array #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory target with fixed wait states
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    state_t            state;
    logic [3:0]        cnt;
    logic              c_write, c_uns;
    logic [ADDR_W-1:0] c_addr;
    logic [1:0]        c_size;
    logic [31:0]       c_wdata;
    logic [1:0]        off;
    logic              enter, err;
    logic [3:0]        be;
    logic [31:0]       wdata_sh, rword, lane, ld_data;

    assign off      = c_addr[1:0];
    assign enter    = state == ST_WAIT && cnt == 4'd0;
    assign err      = is_bad(c_size, off);
    assign be       = (enter && c_write && !err) ? lane_mask(c_size, off) : 4'b0000;
    assign wdata_sh = c_wdata << {off, 3'b000};
    assign lane     = rword >> {off, 3'b000};

    always_comb
        ld_data = c_size == SIZE_B ? {{24{~c_uns & lane[7]}}, lane[7:0]} :
                  c_size == SIZE_H ? {{16{~c_uns & lane[15]}}, lane[15:0]} : lane;

    dmem_array #(.IDX_W(ADDR_W - 2)) u_array (
        .clk   (clk),
        .be    (be),
        .idx   (c_addr[ADDR_W-1:2]),
        .wdata (wdata_sh),
        .rdata (rword)
    );

    // The access is performed on the WAIT->RESP edge, so the response sees the memory state of that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            c_write   <= 1'b0;
            c_uns     <= 1'b0;
            c_addr    <= '0;
            c_size    <= 2'b00;
            c_wdata   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        c_write   <= req_write;
                        c_uns     <= req_unsigned;
                        c_addr    <= req_addr;
                        c_size    <= req_size;
                        c_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        cnt       <= 4'(LATENCY);
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (enter) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || c_write) ? 32'd0 : ld_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks against a byte-array memory model
module tb_dmem_responder;
    import riscv_mem_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_write, req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [256];

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: an access of n bytes must sit on an n-byte boundary.
    function automatic void model(input logic w, input logic [7:0] a, input logic [1:0] s,
                                  input logic u, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int n = (s == SIZE_B) ? 1 : (s == SIZE_H) ? 2 : 4;
        er = (s == 2'b11) || (int'(a) % n != 0);
        rd = 32'd0;
        if (er) return;
        for (int i = 0; i < n; i++)
            if (w) ref_mem[int'(a) + i] = wd[8*i +: 8];
            else   rd = rd | (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (!w && !u && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
    endfunction

    task automatic txn(input logic w, input logic [7:0] a, input logic [1:0] s, input logic u,
                       input logic [31:0] wd, input int stall,
                       output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          n;
        model(w, a, s, u, wd, exp_rd, exp_er);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 8'($urandom); req_wdata = $urandom; req_write = 1'($urandom);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("latency", 32'(n), 32'(LATENCY + 1));
        rd = rsp_rdata;
        er = rsp_err;
        chk("rdata", rd, exp_rd);
        chk("err", 32'(er), 32'(exp_er));
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_W;
            req_addr = a & 8'hFC; req_wdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, rd);
            chk("stall_err", 32'(rsp_err), 32'(er));
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = SIZE_W;
        req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        chk("rel_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel_req_ready_edge", 32'(req_ready), 32'd1);

        txn(1, 8'h10, SIZE_W, 0, 32'hDEAD_BEEF, 0, rd, er);
        chk("st_w_rdata", rd, 32'd0);
        txn(0, 8'h10, SIZE_W, 0, 32'd0, 0, rd, er);
        chk("ld_w", rd, 32'hDEAD_BEEF);
        txn(0, 8'h13, SIZE_B, 0, 32'd0, 0, rd, er);
        chk("ld_b_s", rd, 32'hFFFF_FFDE);
        txn(0, 8'h13, SIZE_B, 1, 32'd0, 0, rd, er);
        chk("ld_b_u", rd, 32'h0000_00DE);
        txn(0, 8'h12, SIZE_H, 0, 32'd0, 0, rd, er);
        chk("ld_h_s", rd, 32'hFFFF_DEAD);
        txn(1, 8'h11, SIZE_B, 0, 32'h0000_0055, 0, rd, er);
        txn(0, 8'h10, SIZE_W, 0, 32'd0, 0, rd, er);
        chk("ld_after_sb", rd, 32'hDEAD_55EF);

        txn(1, 8'h20, SIZE_W, 0, 32'h1234_5678, 0, rd, er);
        txn(1, 8'h22, SIZE_W, 0, 32'hAAAA_AAAA, 0, rd, er);
        chk("mis_sw_err", 32'(er), 32'd1);
        txn(0, 8'h21, SIZE_H, 0, 32'd0, 0, rd, er);
        chk("mis_lh_err", 32'(er), 32'd1);
        chk("mis_lh_rdata", rd, 32'd0);
        txn(1, 8'h20, 2'b11, 0, 32'h5555_5555, 0, rd, er);
        chk("bad_size_err", 32'(er), 32'd1);
        txn(0, 8'h20, SIZE_W, 0, 32'd0, 0, rd, er);
        chk("mem_unchanged", rd, 32'h1234_5678);

        txn(0, 8'h10, SIZE_W, 0, 32'd0, 10, rd, er);
        chk("stall_ld", rd, 32'hDEAD_55EF);
        txn(0, 8'h10, SIZE_W, 0, 32'd0, 0, rd, er);
        chk("stall_ignored", rd, 32'hDEAD_55EF);

        txn(1, 8'h30, SIZE_W, 0, 32'd0, 0, rd, er);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h30; req_size = SIZE_W;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_wait_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_rst_valid", 32'(rsp_valid), 32'd0);
            chk("abort_rst_ready", 32'(req_ready), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_post_valid", 32'(rsp_valid), 32'd0);
        txn(0, 8'h30, SIZE_W, 0, 32'd0, 0, rd, er);
        chk("abort_no_commit", rd, 32'd0);

        for (int i = 0; i < 64; i++)
            txn(1, 8'(4 * i), SIZE_W, 0, $urandom, 0, rd, er);
        for (int i = 0; i < 150; i++)
            txn(1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), $urandom,
                int'($urandom_range(0, 2)), rd, er);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
